audio_gain_ramp: RTL

Stereo output-gain stage between the FIR filter outputs and the LM4550 controller DAC inputs. On each 48 kHz sample strobe it applies a software-set gain to both 18-bit channels with rounding and saturation. Gain changes and mute ramp linearly per sample to avoid zipper noise. One multiplier is shared between the left and right channels through a small FSM. The gain target comes from an ioports output port; status readback goes to an input port.

---
 rtl/audio_gain_pkg.sv | 13 +
 rtl/audio_gain_ramp_if.sv | 26 ++
 rtl/audio_gain_ramp_mul_round_sat.sv | 23 ++
 rtl/audio_gain_ramp.sv | 97 +++++++++
 4 files changed

// File: rtl/audio_gain_pkg.sv
// Shared widths, saturation limits and sequencer states for the output gain stage.
package audio_gain_pkg;
  localparam int DW    = 18;
  localparam int GW    = 16;
  localparam int FRAC  = 14;
  localparam int UNITY = 16384;
  localparam int PW    = DW + GW + 1;

  localparam logic signed [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL_L, MUL_R} state_e;
endpackage

// File: rtl/audio_gain_ramp_if.sv
// Sample/gain/status bundle between the filter/ioports side and the gain stage.
interface audio_gain_ramp_if;
  import audio_gain_pkg::*;

  logic                 data_en;
  logic signed [DW-1:0] left_in;
  logic signed [DW-1:0] right_in;
  logic [GW-1:0]        gain_target;
  logic                 mute;
  logic                 flags_clr;
  logic signed [DW-1:0] left_out;
  logic signed [DW-1:0] right_out;
  logic                 out_valid;
  logic [GW-1:0]        gain_now;
  logic [1:0]           sat_flags;
  logic                 overrun;

  modport master (
    output data_en, left_in, right_in, gain_target, mute, flags_clr,
    input  left_out, right_out, out_valid, gain_now, sat_flags, overrun
  );
  modport slave (
    input  data_en, left_in, right_in, gain_target, mute, flags_clr,
    output left_out, right_out, out_valid, gain_now, sat_flags, overrun
  );
endinterface

// File: rtl/audio_gain_ramp_mul_round_sat.sv
// Signed sample x unsigned Q2.14 gain, round half up, clamp to the sample range.
module mul_round_sat
  import audio_gain_pkg::*;
(
  input  logic signed [DW-1:0] sample,
  input  logic [GW-1:0]        gain,
  output logic signed [DW-1:0] result,
  output logic                 sat
);
  logic signed [PW-1:0]    prod;
  logic signed [PW-1:0]    shifted;
  logic [PW-DW:0]          hi;

  always_comb begin
    prod    = $signed({{(GW+1){sample[DW-1]}}, sample}) * $signed({{DW{1'b0}}, 1'b0, gain});
    shifted = (prod + $signed({{(PW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}})) >>> FRAC;
    // In range only when every bit above the result's sign bit matches it.
    hi      = shifted[PW-1:DW-1];
    sat     = !((&hi) || !(|hi));
    result  = shifted[DW-1:0];
    if (sat) result = shifted[PW-1] ? SMIN : SMAX;
  end
endmodule

// File: rtl/audio_gain_ramp.sv
// Stereo gain stage: per-strobe linear gain ramp, one multiplier shared L then R.
module audio_gain_ramp
  import audio_gain_pkg::*;
#(
  parameter logic [GW-1:0] RAMP_STEP = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  audio_gain_ramp_if.slave  io
);
  state_e               state_q, state_d;
  logic [GW-1:0]        gain_q, gain_d, eff, diff;
  logic signed [DW-1:0] l_smp_q, l_smp_d, r_smp_q, r_smp_d, l_res_q, l_res_d;
  logic signed [DW-1:0] l_out_q, l_out_d, r_out_q, r_out_d;
  logic                 vld_q, vld_d, ovr_q, ovr_d;
  logic [1:0]           sat_q, sat_d;
  logic signed [DW-1:0] mul_in, mul_res;
  logic                 mul_sat;

  assign mul_in = (state_q == MUL_R) ? r_smp_q : l_smp_q;

  mul_round_sat u_mul (.sample(mul_in), .gain(gain_q), .result(mul_res), .sat(mul_sat));

  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    l_smp_d = l_smp_q;
    r_smp_d = r_smp_q;
    l_res_d = l_res_q;
    l_out_d = l_out_q;
    r_out_d = r_out_q;
    vld_d   = 1'b0;
    // Clear first so a same-cycle set below takes priority.
    sat_d   = io.flags_clr ? 2'b00 : sat_q;
    ovr_d   = io.flags_clr ? 1'b0 : ovr_q;
    eff     = io.mute ? '0 : io.gain_target;
    diff    = (eff > gain_q) ? (eff - gain_q) : (gain_q - eff);
    case (state_q)
      IDLE: if (io.data_en) begin
        state_d = MUL_L;
        l_smp_d = io.left_in;
        r_smp_d = io.right_in;
        if (diff <= RAMP_STEP)  gain_d = eff;
        else if (eff > gain_q)  gain_d = gain_q + RAMP_STEP;
        else                    gain_d = gain_q - RAMP_STEP;
      end
      MUL_L: begin
        state_d = MUL_R;
        l_res_d = mul_res;
        if (mul_sat)    sat_d[0] = 1'b1;
        if (io.data_en) ovr_d    = 1'b1;
      end
      MUL_R: begin
        state_d = IDLE;
        l_out_d = l_res_q;
        r_out_d = mul_res;
        vld_d   = 1'b1;
        if (mul_sat)    sat_d[1] = 1'b1;
        if (io.data_en) ovr_d    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      gain_q  <= '0;
      l_smp_q <= '0;
      r_smp_q <= '0;
      l_res_q <= '0;
      l_out_q <= '0;
      r_out_q <= '0;
      vld_q   <= 1'b0;
      sat_q   <= 2'b00;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
      l_smp_q <= l_smp_d;
      r_smp_q <= r_smp_d;
      l_res_q <= l_res_d;
      l_out_q <= l_out_d;
      r_out_q <= r_out_d;
      vld_q   <= vld_d;
      sat_q   <= sat_d;
      ovr_q   <= ovr_d;
    end
  end

  assign io.left_out  = l_out_q;
  assign io.right_out = r_out_q;
  assign io.out_valid = vld_q;
  assign io.gain_now  = gain_q;
  assign io.sat_flags = sat_q;
  assign io.overrun   = ovr_q;
endmodule
